gcd_ctrl: RTL and testbench



---
 rtl/gcd_pkg.sv | 72 +++++++
 rtl/sat_counter.sv | 51 +++++
 rtl/gcd_ctrl.sv | 113 +++++++++++
 tb/tb_gcd_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// ----------------------------------------------------------------------------
// gcd_pkg
//   Shared definitions for the GCD accelerator: controller state encoding,
//   operand-register mux select encodings (also used by the datapath) and a
//   small control-word type with helpers that build the common words.
// ----------------------------------------------------------------------------
package gcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // A register input select
   localparam logic [1:0] A_MUX_SEL_IN  = 2'd0;
   localparam logic [1:0] A_MUX_SEL_SUB = 2'd1;
   localparam logic [1:0] A_MUX_SEL_B   = 2'd2;

   // B register input select
   localparam logic B_MUX_SEL_A  = 1'b0;
   localparam logic B_MUX_SEL_IN = 1'b1;

   // Datapath control word driven by the controller each cycle
   typedef struct packed {
      logic       a_en;
      logic       b_en;
      logic [1:0] a_sel;
      logic       b_sel;
   } ctrl_t;

   // Everything off; selects parked at encoding 0 so nothing floats to X.
   function automatic ctrl_t ctrl_off();
      ctrl_t c;
      c.a_en  = 1'b0;
      c.b_en  = 1'b0;
      c.a_sel = A_MUX_SEL_IN;
      c.b_sel = B_MUX_SEL_A;
      return c;
   endfunction

   // Load both operands from the request inputs
   function automatic ctrl_t ctrl_load();
      ctrl_t c;
      c.a_en  = 1'b1;
      c.b_en  = 1'b1;
      c.a_sel = A_MUX_SEL_IN;
      c.b_sel = B_MUX_SEL_IN;
      return c;
   endfunction

   // Exchange A and B
   function automatic ctrl_t ctrl_swap();
      ctrl_t c;
      c.a_en  = 1'b1;
      c.b_en  = 1'b1;
      c.a_sel = A_MUX_SEL_B;
      c.b_sel = B_MUX_SEL_A;
      return c;
   endfunction

   // A <= A - B, B untouched
   function automatic ctrl_t ctrl_sub();
      ctrl_t c;
      c.a_en  = 1'b1;
      c.b_en  = 1'b0;
      c.a_sel = A_MUX_SEL_SUB;
      c.b_sel = B_MUX_SEL_A;
      return c;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter for profiling. Clear has priority over increment;
//   once the all-ones value is reached the count sticks there.
// Ports:
//   clk     in   clock
//   reset   in   synchronous active-high reset (count -> 0)
//   clr_i   in   synchronous clear
//   inc_i   in   increment by one (saturating)
//   count_o out  current count
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [DATA_W-1:0] count_o
);

   logic [DATA_W-1:0] count_q;
   logic [DATA_W-1:0] count_d;

   function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + DATA_W'(1);
   endfunction

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = sat_inc(count_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/gcd_ctrl.sv
// ----------------------------------------------------------------------------
// gcd_ctrl
//   Control unit for the GCD accelerator. Sequences a val/rdy request and
//   response around the subtract-and-swap datapath, drives the operand
//   register enables and mux selects, and counts working CALC cycles
//   (saturating) for profiling.
// Ports:
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   req_val     in   request operands valid on datapath inputs
//   req_rdy     out  controller can accept a request (IDLE only)
//   resp_val    out  result in the A register is valid (DONE)
//   resp_rdy    in   consumer accepts the result
//   is_a_lt_b   in   datapath status A < B (unsigned)
//   is_b_zero   in   datapath status B == 0
//   a_reg_en    out  A register enable
//   b_reg_en    out  B register enable
//   a_mux_sel   out  A input select (IN / SUB / B)
//   b_mux_sel   out  B input select (A / IN)
//   resp_iters  out  working CALC cycles for the current result
// ----------------------------------------------------------------------------
module gcd_ctrl
   import gcd_pkg::*;
#(
   parameter int ITER_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_val,
   output logic              req_rdy,
   output logic              resp_val,
   input  logic              resp_rdy,
   input  logic              is_a_lt_b,
   input  logic              is_b_zero,
   output logic              a_reg_en,
   output logic              b_reg_en,
   output logic [1:0]        a_mux_sel,
   output logic              b_mux_sel,
   output logic [ITER_W-1:0] resp_iters
);

   state_e state_q;
   state_e state_d;
   ctrl_t  ctrl;
   logic   iter_clr;
   logic   iter_inc;

   always_comb begin
      state_d  = state_q;
      ctrl     = ctrl_off();
      req_rdy  = 1'b0;
      resp_val = 1'b0;
      iter_clr = 1'b0;
      iter_inc = 1'b0;
      case (state_q)
         IDLE: begin
            // Operands are loaded every idle cycle; the one present at
            // acceptance is the one that sticks.
            req_rdy = 1'b1;
            ctrl    = ctrl_load();
            if (req_val) begin
               iter_clr = 1'b1;
               state_d  = CALC;
            end
         end
         CALC: begin
            // Swap is tested first so A=0,B=0 falls straight through to done.
            if (is_a_lt_b) begin
               ctrl     = ctrl_swap();
               iter_inc = 1'b1;
            end else if (!is_b_zero) begin
               ctrl     = ctrl_sub();
               iter_inc = 1'b1;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            resp_val = 1'b1;
            if (resp_rdy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   sat_counter #(
      .DATA_W (ITER_W)
   ) u_iter_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (iter_clr),
      .inc_i   (iter_inc),
      .count_o (resp_iters)
   );

   assign a_reg_en  = ctrl.a_en;
   assign b_reg_en  = ctrl.b_en;
   assign a_mux_sel = ctrl.a_sel;
   assign b_mux_sel = ctrl.b_sel;

endmodule

// File: tb/tb_gcd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_gcd_ctrl
//   Two controllers (ITER_W=16 and ITER_W=3) share one stimulus stream, each
//   driving its own behavioural operand datapath. A stimulus process issues
//   requests and pushes expected results; a negedge monitor pops and checks
//   whenever resp_val rises, and checks hold behaviour while it stays high.
// ----------------------------------------------------------------------------
module tb_gcd_ctrl;
   import gcd_pkg::*;

   typedef struct {
      int res;
      int iters;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset    = 1'b1;
   logic        req_val  = 1'b0;
   logic        resp_rdy = 1'b1;
   logic [15:0] in_a     = '0;
   logic [15:0] in_b     = '0;

   // wide-counter instance
   logic        req_rdy, resp_val, lt, bz, a_en, b_en, b_sel;
   logic [1:0]  a_sel;
   logic [15:0] iters;
   logic [15:0] ra = '0;
   logic [15:0] rb = '0;

   // 3-bit counter instance
   logic        s_req_rdy, s_resp_val, s_lt, s_bz, s_a_en, s_b_en, s_b_sel;
   logic [1:0]  s_a_sel;
   logic [2:0]  s_iters;
   logic [15:0] sa = '0;
   logic [15:0] sb_r = '0;

   gcd_ctrl #(.ITER_W(16)) dut (
      .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
      .resp_val(resp_val), .resp_rdy(resp_rdy), .is_a_lt_b(lt), .is_b_zero(bz),
      .a_reg_en(a_en), .b_reg_en(b_en), .a_mux_sel(a_sel), .b_mux_sel(b_sel),
      .resp_iters(iters)
   );

   gcd_ctrl #(.ITER_W(3)) dut_sat (
      .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(s_req_rdy),
      .resp_val(s_resp_val), .resp_rdy(resp_rdy), .is_a_lt_b(s_lt), .is_b_zero(s_bz),
      .a_reg_en(s_a_en), .b_reg_en(s_b_en), .a_mux_sel(s_a_sel), .b_mux_sel(s_b_sel),
      .resp_iters(s_iters)
   );

   // Behavioural operand datapaths
   always @(posedge clk) begin
      if (a_en) begin
         case (a_sel)
            A_MUX_SEL_IN:  ra <= in_a;
            A_MUX_SEL_SUB: ra <= ra - rb;
            A_MUX_SEL_B:   ra <= rb;
            default:       ra <= 16'hdead;
         endcase
      end
      if (b_en) rb <= (b_sel == B_MUX_SEL_A) ? ra : in_b;
   end
   assign lt = (ra < rb);
   assign bz = (rb == 16'd0);

   always @(posedge clk) begin
      if (s_a_en) begin
         case (s_a_sel)
            A_MUX_SEL_IN:  sa <= in_a;
            A_MUX_SEL_SUB: sa <= sa - sb_r;
            A_MUX_SEL_B:   sa <= sb_r;
            default:       sa <= 16'hdead;
         endcase
      end
      if (s_b_en) sb_r <= (s_b_sel == B_MUX_SEL_A) ? sa : in_b;
   end
   assign s_lt = (sa < sb_r);
   assign s_bz = (sb_r == 16'd0);

   // Reference model: Euclid by remainders. Each quotient step costs q
   // subtractions, and every remainder phase ends with one swap.
   function automatic exp_t ref_model(input int a, input int b);
      exp_t e;
      int   x, y, t, n;
      x = a;
      y = b;
      n = 0;
      if (x < y) begin
         t = x; x = y; y = t; n++;
      end
      while (y != 0) begin
         n += x / y;
         t = x % y;
         x = y;
         y = t;
         n++;
      end
      e.res   = x;
      e.iters = n;
      return e;
   endfunction

   exp_t sbq[$];
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   n_resp   = 0;
   int   chk_req  = 0;
   int   chk_done = 0;
   int   idle_v   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor / scoreboard
   int          ncyc    = 0;
   int          acc_cyc = 0;
   bit          seen    = 1'b0;
   logic [15:0] held_a  = '0;
   logic [15:0] held_it = '0;
   exp_t        me;

   always @(negedge clk) begin
      ncyc++;
      if (chk_req != chk_done) begin
         chk_done = chk_req;
         chk("idle_req_rdy", req_rdy, 1);
         chk("idle_resp_val", resp_val, 0);
         chk("idle_iters", iters, idle_v);
         chk("idle_sat_req_rdy", s_req_rdy, 1);
         chk("idle_sat_iters", s_iters, (idle_v > 7) ? 7 : idle_v);
      end
      if (!reset && req_val && req_rdy) acc_cyc = ncyc;
      if (resp_val && !seen) begin
         seen = 1'b1;
         if (sbq.size() == 0) begin
            chk("unexpected_resp", resp_val, 0);
         end else begin
            me = sbq.pop_front();
            chk("result", ra, me.res);
            chk("iters", iters, me.iters);
            chk("latency", ncyc - acc_cyc, me.iters + 2);
            chk("sat_resp_val", s_resp_val, 1);
            chk("sat_result", sa, me.res);
            chk("sat_iters", s_iters, (me.iters > 7) ? 7 : me.iters);
         end
         held_a  = ra;
         held_it = iters;
      end else if (resp_val) begin
         chk("hold_a", ra, held_a);
         chk("hold_iters", iters, held_it);
         chk("hold_req_rdy", req_rdy, 0);
         chk("hold_enables", {a_en, b_en, s_a_en, s_b_en}, 0);
      end
      if (resp_val && resp_rdy) n_resp++;
      if (!resp_val || resp_rdy) seen = 1'b0;
   end

   // Stimulus helpers (inputs change 1 time unit after posedge)
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ask_idle(input int v);
      idle_v = v;
      chk_req++;
   endtask

   task automatic send(input int a, input int b, input bit push, input bit use_model,
                       input int r, input int n);
      exp_t e;
      int   k;
      k = 0;
      while (!req_rdy && k < 5000) begin
         tick();
         k++;
      end
      if (!req_rdy) begin
         $display("FAIL req_rdy_timeout: got 0 expected 1");
         $fatal(1, "stalled");
      end
      if (use_model) begin
         e = ref_model(a, b);
      end else begin
         e.res   = r;
         e.iters = n;
      end
      if (push) sbq.push_back(e);
      in_a    = a[15:0];
      in_b    = b[15:0];
      req_val = 1'b1;
      tick();
      req_val = 1'b0;
   endtask

   task automatic wait_resp(input int target, input bit rnd);
      int k;
      k = 0;
      while (n_resp < target && k < 5000) begin
         tick();
         if (rnd) resp_rdy = 1'($urandom_range(0, 1));
         k++;
      end
      if (n_resp < target) begin
         $display("FAIL resp_timeout: got %0d expected %0d", n_resp, target);
         $fatal(1, "stalled");
      end
      resp_rdy = 1'b1;
   endtask

   int nexp = 0;

   initial begin
      // Reset held two cycles with a request pending: nothing is accepted
      reset   = 1'b1;
      req_val = 1'b1;
      in_a    = 16'd15;
      in_b    = 16'd5;
      tick();
      ask_idle(0);
      tick();
      reset   = 1'b0;
      req_val = 1'b0;
      ask_idle(0);
      tick();
      ask_idle(0);
      tick();

      // Directed vectors with known answers
      send(15, 5, 1, 0, 5, 4);   nexp++; wait_resp(nexp, 0);
      send(7, 0, 1, 0, 7, 0);    nexp++; wait_resp(nexp, 0);
      send(5, 15, 1, 0, 5, 5);   nexp++; wait_resp(nexp, 0);
      send(0, 0, 1, 0, 0, 0);    nexp++; wait_resp(nexp, 0);
      send(15, 1, 1, 0, 1, 16);  nexp++; wait_resp(nexp, 0);

      // Backpressure: response held 10 cycles
      resp_rdy = 1'b0;
      send(15, 5, 1, 0, 5, 4);
      nexp++;
      for (int k = 0; k < 200 && !resp_val; k++) tick();
      repeat (10) tick();
      resp_rdy = 1'b1;
      tick();
      ask_idle(4);
      wait_resp(nexp, 0);

      // Reset in the second CALC cycle drops the request
      send(15, 5, 0, 0, 0, 0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      ask_idle(0);
      repeat (10) tick();
      send(9, 6, 1, 1, 0, 0);    nexp++; wait_resp(nexp, 0);

      // Randomised operands and response backpressure
      for (int i = 0; i < 25; i++) begin
         int a, b;
         a = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 250));
         b = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 250));
         send(a, b, 1, 1, 0, 0);
         nexp++;
         wait_resp(nexp, 1);
      end

      repeat (5) tick();
      if (sbq.size() != 0) begin
         $display("FAIL scoreboard_drain: got %0d expected 0", sbq.size());
         $fatal(1, "leftover expectations");
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
